axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Shares one memory read port (AR/R channels) among NUM_MASTERS requesters, e.g. IFU fetch (master 0) and LSU load (master 1).
- Accepts one read at a time, forwards it to the single slave, and routes the returned data back to the granted master.
- Holds the slave AR request until the R handshake completes. This matches the memory slaves, which only drive R_DATA while AR_VALID, AR_READY, R_VALID and R_READY are all high.
- Includes a watchdog that forces a response when the slave never answers.

Parameters:
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, read data width.
- NUM_MASTERS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, busy cycles before a forced response; 0 disables the watchdog.

Ports:
- CLK  in  1  single clock, all logic on posedge.
- RESET  in  1  synchronous active-high reset.
- M_AR_ADDR  in  NUM_MASTERS*ADDR_WIDTH  master i address at [i*ADDR_WIDTH +: ADDR_WIDTH].
- M_AR_VALID  in  NUM_MASTERS  per-master read request.
- M_AR_READY  out  NUM_MASTERS  per-master address accept.
- M_R_DATA  out  NUM_MASTERS*DATA_WIDTH  per-master read data, same slicing as M_AR_ADDR.
- M_R_VALID  out  NUM_MASTERS  per-master data valid.
- M_R_READY  in  NUM_MASTERS  per-master data ready.
- S_AR_ADDR  out  ADDR_WIDTH  slave read address.
- S_AR_VALID  out  1  slave read request.
- S_AR_READY  in  1  slave address accept.
- S_R_DATA  in  DATA_WIDTH  slave read data.
- S_R_VALID  in  1  slave data valid.
- S_R_READY  out  1  ready toward slave.
- ERR  out  1  sticky watchdog-timeout flag.

Behaviour:
- Clock and reset: one clock CLK; RESET is synchronous and active-high.
- Reset values:
  - All outputs 0.
  - State IDLE; grant index 0; latched address 0; watchdog counter 0; ERR 0.
  - Round-robin pointer 0 when ARB_RR_EN is defined.
- States: IDLE, BUSY, TO_RESP.
- IDLE:
  - If any M_AR_VALID is set, select winner g (priority rule below).
  - M_AR_READY[g] is driven combinationally high in this same cycle; the master's AR handshake completes at this edge.
  - At the edge: latch M_AR_ADDR[g], register g, clear the counter, go to BUSY.
  - No request: remain in IDLE with all outputs 0.
- BUSY:
  - S_AR_VALID=1 and S_AR_ADDR=latched address every cycle, regardless of S_AR_READY. The request is held until R completes.
  - S_R_READY=M_R_READY[g].
  - M_R_VALID[g]=S_R_VALID and M_R_DATA[g]=S_R_DATA. Non-granted M_R_VALID and M_R_DATA are 0.
  - All M_AR_READY are 0.
  - On S_R_VALID && S_R_READY: go to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0): go to TO_RESP and set ERR.
- TO_RESP:
  - S_AR_VALID=0 and S_R_READY=0.
  - M_R_VALID[g]=1 with M_R_DATA[g]=0.
  - On M_R_READY[g]: go to IDLE.
- Latency and request timing:
  - AR is accepted in the first cycle M_AR_VALID is seen in IDLE (0 wait).
  - S_AR_VALID rises 1 cycle after acceptance.
  - One IDLE bubble always follows a completion. A request pending during the completion cycle is granted in the following IDLE cycle.
- Granted master behaviour:
  - The granted master may deassert M_AR_VALID after its handshake; the arbiter does not re-sample it.
  - A master that keeps M_R_READY low stalls the slave indefinitely; only the watchdog resolves this.
- Simultaneous completion and new requests: the state returns to IDLE first; arbitration never uses stale grant state.
- RESET mid-transaction: the transaction is aborted without any response to the master, and all outputs are 0 the cycle after. A master still holding M_AR_VALID is re-arbitrated after RESET deasserts.
- ERR stays set until RESET; later transactions proceed normally.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at (last_grant+1) mod NUM_MASTERS, and the pointer updates on every grant, so no master waits more than NUM_MASTERS-1 grants.
- Undefined: fixed priority, lowest index wins (IFU over LSU). The pointer register is not instantiated.

Test Plan:
1. Master 0 only, addr 0x8000_0000, slave returns 0x0000_0413 after 1 cycle -> M_AR_READY[0] pulses once in the request cycle, S_AR_ADDR=0x8000_0000 held through BUSY, M_R_DATA[0]=0x413 with M_R_VALID[0]=1, M_R_VALID[1]=0 throughout.
2. Both masters request continuously, 4 transactions:
   - ARB_RR_EN undefined: grants 0,0,0,0.
   - ARB_RR_EN defined: grants 0,1,0,1, each separated by one IDLE bubble.
3. Master 1 granted, M_R_READY[1] low for 5 cycles -> S_R_READY=0, S_AR_VALID stays 1, state BUSY. Data is delivered in the cycle M_R_READY[1] rises.
4. TIMEOUT_CYCLES=16, slave never asserts S_R_VALID -> after 16 BUSY cycles S_AR_VALID drops, M_R_VALID[g]=1 with data 0, ERR=1. A following normal read completes and ERR stays 1.
5. RESET asserted during BUSY while master 0 keeps M_AR_VALID high -> all outputs 0 next cycle. Master 0 is re-granted in the first cycle after RESET deasserts, and ERR=0.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: the AR/R bundle shared by the requesters, the arbiter and the memory slave.
//   M_AR_* / M_R_*  per-master request/response.
//                   Masters are packed flat: master i sits at [i*W +: W].
//   S_AR_* / S_R_*  single slave read port.
//   ERR             sticky watchdog flag.
// Modports:
//   slave  - the arbiter's view. It is the slave of the requesters.
//   master - the environment's view. This is the requesters plus the memory.
interface axi_read_arbiter_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_AR_ADDR;
  logic [NUM_MASTERS-1:0]            M_AR_VALID;
  logic [NUM_MASTERS-1:0]            M_AR_READY;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_R_DATA;
  logic [NUM_MASTERS-1:0]            M_R_VALID;
  logic [NUM_MASTERS-1:0]            M_R_READY;
  logic [ADDR_WIDTH-1:0]             S_AR_ADDR;
  logic                              S_AR_VALID;
  logic                              S_AR_READY;
  logic [DATA_WIDTH-1:0]             S_R_DATA;
  logic                              S_R_VALID;
  logic                              S_R_READY;
  logic                              ERR;

  modport slave (
    input  M_AR_ADDR, M_AR_VALID, M_R_READY, S_AR_READY, S_R_DATA, S_R_VALID,
    output M_AR_READY, M_R_DATA, M_R_VALID, S_AR_ADDR, S_AR_VALID, S_R_READY, ERR
  );

  modport master (
    output M_AR_ADDR, M_AR_VALID, M_R_READY, S_AR_READY, S_R_DATA, S_R_VALID,
    input  M_AR_READY, M_R_DATA, M_R_VALID, S_AR_ADDR, S_AR_VALID, S_R_READY, ERR
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AR/R read port among NUM_MASTERS requesters.
// It carries one read at a time.
//
// Ports:
//   CLK    single clock; all logic runs on posedge.
//   RESET  synchronous, active-high.
//   bus    axi_read_arbiter_if.slave. It carries the per-master AR/R, the slave AR/R and ERR.
//
// Optional feature, macro ARB_RR_EN:
//   Defined   - round-robin arbitration. The search starts after the last grant.
//   Undefined - fixed priority; the lowest index wins.
//
// The slave AR request is held until R completes. The memory slaves drive
// R_DATA only while AR_VALID, AR_READY, R_VALID and R_READY are all high.
// A watchdog forces a zero-data response after TIMEOUT_CYCLES busy cycles.
// TIMEOUT_CYCLES = 0 disables it.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic               CLK,
  input logic               RESET,
  axi_read_arbiter_if.slave bus
);
  localparam int GW      = $clog2(NUM_MASTERS);
  localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, TO_RESP} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [GW-1:0]         win;

  logic [NUM_MASTERS-1:0]            m_ar_ready;
  logic [NUM_MASTERS-1:0]            m_r_valid;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_r_data;
  logic                              s_ar_valid;
  logic                              s_r_ready;
  logic [ADDR_WIDTH-1:0]             s_ar_addr;

  // AR_READY from the slave is not needed: the request is held until R anyway.
  logic unused_s_ar_ready;
  assign unused_s_ar_ready = bus.S_AR_READY;

`ifdef ARB_RR_EN
  // Holds the index where the next search starts, i.e. last grant + 1.
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  int            rr_idx;
  logic          found;

  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      rr_idx = int'(rr_ptr_q) + k;
      if (rr_idx >= NUM_MASTERS) rr_idx = rr_idx - NUM_MASTERS;
      if (!found && bus.M_AR_VALID[GW'(rr_idx)]) begin
        win   = GW'(rr_idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && |bus.M_AR_VALID && !RESET)
      rr_ptr_d = (int'(win) == NUM_MASTERS - 1) ? '0 : win + GW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    win = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (bus.M_AR_VALID[k]) win = GW'(k);
  end
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    m_ar_ready = '0;
    m_r_valid  = '0;
    m_r_data   = '0;
    s_ar_valid = 1'b0;
    s_r_ready  = 1'b0;
    s_ar_addr  = '0;
    unique case (state_q)
      IDLE: begin
        // Gate on RESET so nothing is accepted while the block is held in reset.
        if (|bus.M_AR_VALID && !RESET) begin
          m_ar_ready[win] = 1'b1;
          gnt_d           = win;
          addr_d          = bus.M_AR_ADDR[win*ADDR_WIDTH +: ADDR_WIDTH];
          cnt_d           = '0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        s_ar_valid                                  = 1'b1;
        s_ar_addr                                   = addr_q;
        s_r_ready                                   = bus.M_R_READY[gnt_q];
        m_r_valid[gnt_q]                            = bus.S_R_VALID;
        m_r_data[gnt_q*DATA_WIDTH +: DATA_WIDTH]    = bus.S_R_DATA;
        if (bus.S_R_VALID && bus.M_R_READY[gnt_q]) begin
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == CW'(TO_LAST)) begin
          state_d = TO_RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TO_RESP: begin
        m_r_valid[gnt_q] = 1'b1;
        if (bus.M_R_READY[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.M_AR_READY = m_ar_ready;
  assign bus.M_R_VALID  = m_r_valid;
  assign bus.M_R_DATA   = m_r_data;
  assign bus.S_AR_VALID = s_ar_valid;
  assign bus.S_AR_ADDR  = s_ar_addr;
  assign bus.S_R_READY  = s_r_ready;
  assign bus.ERR        = err_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter with 2 masters and TIMEOUT_CYCLES = 16.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_axi_read_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  axi_read_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_MASTERS(2)) bus ();

  axi_read_arbiter #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_MASTERS(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [1:0]   eg;
    logic [127:0] ed;

    RESET = 1'b1;
    bus.M_AR_ADDR  = '0;
    bus.M_AR_VALID = '0;
    bus.M_R_READY  = '0;
    bus.S_AR_READY = 1'b1;
    bus.S_R_DATA   = '0;
    bus.S_R_VALID  = 1'b0;
    step(); step();
    samp();
    chk("rst_ar_ready", bus.M_AR_READY, 0);
    chk("rst_s_ar_valid", bus.S_AR_VALID, 0);
    chk("rst_m_r_valid", bus.M_R_VALID, 0);
    chk("rst_err", bus.ERR, 0);

    // Test 1: master 0 alone, 1-cycle slave response.
    step();
    RESET = 1'b0;
    bus.M_AR_ADDR  = {64'h0, 64'h8000_0000};
    bus.M_AR_VALID = 2'b01;
    bus.M_R_READY  = 2'b11;
    samp();
    chk("t1_ar_ready", bus.M_AR_READY, 2'b01);
    chk("t1_s_ar_valid_idle", bus.S_AR_VALID, 0);
    step();
    bus.M_AR_VALID = 2'b00;
    samp();
    chk("t1_ar_ready_once", bus.M_AR_READY, 0);
    chk("t1_s_ar_valid", bus.S_AR_VALID, 1);
    chk("t1_s_ar_addr", bus.S_AR_ADDR, 64'h8000_0000);
    chk("t1_r_valid_wait", bus.M_R_VALID, 0);
    step();
    bus.S_R_VALID = 1'b1;
    bus.S_R_DATA  = 64'h413;
    samp();
    chk("t1_s_ar_addr_held", bus.S_AR_ADDR, 64'h8000_0000);
    chk("t1_r_valid", bus.M_R_VALID, 2'b01);
    chk("t1_r_data", bus.M_R_DATA, 128'h413);
    chk("t1_s_r_ready", bus.S_R_READY, 1);
    step();
    bus.S_R_VALID = 1'b0;
    samp();
    chk("t1_done_s_ar_valid", bus.S_AR_VALID, 0);
    chk("t1_done_r_valid", bus.M_R_VALID, 0);

    // Test 2: both masters request continuously. Reset first so the RR pointer is known.
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    bus.M_AR_ADDR  = {64'h2000, 64'h1000};
    bus.M_AR_VALID = 2'b11;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
      eg = 2'(t % 2);
`else
      eg = 2'd0;
`endif
      samp();
      chk("t2_ar_ready", bus.M_AR_READY, 2'b01 << eg);
      chk("t2_bubble", bus.S_AR_VALID, 0);
      step();
      bus.S_R_VALID = 1'b1;
      bus.S_R_DATA  = 64'h100 + 64'(t);
      ed = 128'(64'h100 + 64'(t)) << (64 * eg);
      samp();
      chk("t2_s_ar_addr", bus.S_AR_ADDR, (eg == 0) ? 64'h1000 : 64'h2000);
      chk("t2_r_valid", bus.M_R_VALID, 2'b01 << eg);
      chk("t2_r_data", bus.M_R_DATA, ed);
      step();
      bus.S_R_VALID = 1'b0;
    end
    bus.M_AR_VALID = 2'b00;
    step();

    // Test 3: master 1 holds R_READY low for 5 cycles.
    bus.M_AR_ADDR  = {64'h3000, 64'h0};
    bus.M_AR_VALID = 2'b10;
    bus.M_R_READY  = 2'b01;
    samp();
    chk("t3_ar_ready", bus.M_AR_READY, 2'b10);
    step();
    bus.M_AR_VALID = 2'b00;
    bus.S_R_VALID  = 1'b1;
    bus.S_R_DATA   = 64'hBEEF;
    for (int i = 0; i < 5; i++) begin
      samp();
      chk("t3_s_r_ready_low", bus.S_R_READY, 0);
      chk("t3_s_ar_valid_held", bus.S_AR_VALID, 1);
      step();
    end
    bus.M_R_READY = 2'b11;
    samp();
    chk("t3_s_r_ready", bus.S_R_READY, 1);
    chk("t3_r_valid", bus.M_R_VALID, 2'b10);
    chk("t3_r_data", bus.M_R_DATA, {64'hBEEF, 64'h0});
    step();
    bus.S_R_VALID = 1'b0;
    samp();
    chk("t3_done", bus.S_AR_VALID, 0);

    // Test 4: watchdog after 16 busy cycles, then a normal read.
    step();
    bus.M_AR_ADDR  = {64'h0, 64'h4000};
    bus.M_AR_VALID = 2'b01;
    bus.M_R_READY  = 2'b00;
    samp();
    chk("t4_ar_ready", bus.M_AR_READY, 2'b01);
    step();
    bus.M_AR_VALID = 2'b00;
    for (int i = 0; i < 16; i++) begin
      samp();
      chk("t4_busy_s_ar_valid", bus.S_AR_VALID, 1);
      chk("t4_busy_err", bus.ERR, 0);
      step();
    end
    samp();
    chk("t4_to_s_ar_valid", bus.S_AR_VALID, 0);
    chk("t4_to_s_r_ready", bus.S_R_READY, 0);
    chk("t4_to_r_valid", bus.M_R_VALID, 2'b01);
    chk("t4_to_r_data", bus.M_R_DATA, 0);
    chk("t4_err", bus.ERR, 1);
    step();
    samp();
    chk("t4_to_hold", bus.M_R_VALID, 2'b01);
    step();
    bus.M_R_READY = 2'b11;
    samp();
    chk("t4_to_accept", bus.M_R_VALID, 2'b01);
    step();
    bus.M_AR_ADDR  = {64'h5000, 64'h0};
    bus.M_AR_VALID = 2'b10;
    samp();
    chk("t4_next_ar_ready", bus.M_AR_READY, 2'b10);
    step();
    bus.M_AR_VALID = 2'b00;
    bus.S_R_VALID  = 1'b1;
    bus.S_R_DATA   = 64'h55;
    samp();
    chk("t4_next_addr", bus.S_AR_ADDR, 64'h5000);
    chk("t4_next_data", bus.M_R_DATA, {64'h55, 64'h0});
    step();
    bus.S_R_VALID = 1'b0;
    samp();
    chk("t4_err_sticky", bus.ERR, 1);

    // Test 5: reset mid-BUSY while master 0 keeps requesting.
    step();
    bus.M_AR_ADDR  = {64'h0, 64'h6000};
    bus.M_AR_VALID = 2'b01;
    samp();
    chk("t5_ar_ready", bus.M_AR_READY, 2'b01);
    step();
    samp();
    chk("t5_busy", bus.S_AR_VALID, 1);
    step();
    RESET = 1'b1;
    step();
    samp();
    chk("t5_rst_ar_ready", bus.M_AR_READY, 0);
    chk("t5_rst_s_ar_valid", bus.S_AR_VALID, 0);
    chk("t5_rst_r_valid", bus.M_R_VALID, 0);
    chk("t5_rst_err", bus.ERR, 0);
    step();
    RESET = 1'b0;
    samp();
    chk("t5_regrant", bus.M_AR_READY, 2'b01);
    chk("t5_err_clear", bus.ERR, 0);
    step();
    samp();
    chk("t5_regrant_addr", bus.S_AR_ADDR, 64'h6000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
